// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: slot states, controller data width
// and the byte-replication helper used for the controller write data.
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, SCPU, SRFS, SDMA} arb_state_t;

    localparam int SDR_DW = 16;

    function automatic logic [SDR_DW-1:0] dup_byte(input logic [7:0] b);
        return {b, b};
    endfunction

endpackage

// File: rtl/sdram_arbiter_edge.sv
// Rising-edge detector on a level request, compared against the registered
// previous level; one instance per CPU request line.
module arb_edge (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    output logic rise
);

    logic prev_q, prev_d;

    always_comb prev_d = lvl;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= prev_d;
    end

    assign rise = lvl & ~prev_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Fixed-slot arbiter for the SDRAM controller port: Z80 memory, Z80 refresh, DMA loader.
// Optional refresh watchdog enabled by defining SDRAM_ARB_WDT_EN.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW   = 24,
    parameter int SLOT = 8,
    parameter int WDT  = 2048
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ready,
    input  logic              cpuRd,
    input  logic              cpuWr,
    input  logic              cpuRf,
    input  logic [AW-1:0]     cpuA,
    input  logic [7:0]        cpuD,
    output logic [7:0]        cpuQ,
    input  logic              dmaReq,
    input  logic              dmaWe,
    input  logic [AW-1:0]     dmaA,
    input  logic [7:0]        dmaD,
    output logic [7:0]        dmaQ,
    output logic              dmaAck,
    output logic              sdrRd,
    output logic              sdrWr,
    output logic              sdrRf,
    output logic [AW-1:0]     sdrA,
    output logic [SDR_DW-1:0] sdrD,
    input  logic [SDR_DW-1:0] sdrQ,
    output logic              busy
);

    localparam int CW = (SLOT > 1) ? $clog2(SLOT) : 1;

    logic [2:0] rise;

    arb_edge u_edge [2:0] (
        .clk  (clock),
        .rst  (reset),
        .lvl  ({cpuRf, cpuWr, cpuRd}),
        .rise (rise)
    );

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              cpu_wr_q, cpu_wr_d;
    logic [AW-1:0]     cpu_a_q, cpu_a_d;
    logic [7:0]        cpu_d_q, cpu_d_d;
    logic [1:0]        rf_cnt_q, rf_cnt_d;
    logic              slot_wr_q, slot_wr_d;
    logic              sdr_rd_q, sdr_rd_d;
    logic              sdr_wr_q, sdr_wr_d;
    logic              sdr_rf_q, sdr_rf_d;
    logic [AW-1:0]     sdr_a_q, sdr_a_d;
    logic [SDR_DW-1:0] sdr_d_q, sdr_d_d;
    logic [7:0]        cpu_q_q, cpu_q_d;
    logic [7:0]        dma_q_q, dma_q_d;
    logic              dma_ack_q, dma_ack_d;
    logic              last, rf_dec, wdt_hit;

    logic unused_sdrq;
    assign unused_sdrq = ^sdrQ[SDR_DW-1:8];

`ifdef SDRAM_ARB_WDT_EN
    localparam int WW = $clog2(WDT + 1);
    logic [WW-1:0] wdt_q, wdt_d;

    // Held clear for the whole refresh slot, so the forced period is WDT+SLOT+1.
    always_comb begin
        wdt_hit = (wdt_q == WW'(WDT)) && (state_q != SRFS);
        wdt_d   = (state_q == SRFS || wdt_hit) ? '0 : wdt_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) wdt_q <= '0;
        else       wdt_q <= wdt_d;
    end
`else
    localparam int unused_wdt = WDT;
    assign wdt_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpu_pend_d = cpu_pend_q;
        cpu_wr_d   = cpu_wr_q;
        cpu_a_d    = cpu_a_q;
        cpu_d_d    = cpu_d_q;
        rf_cnt_d   = rf_cnt_q;
        slot_wr_d  = slot_wr_q;
        sdr_rd_d   = 1'b0;
        sdr_wr_d   = 1'b0;
        sdr_rf_d   = 1'b0;
        sdr_a_d    = sdr_a_q;
        sdr_d_d    = sdr_d_q;
        cpu_q_d    = cpu_q_q;
        dma_q_d    = dma_q_q;
        dma_ack_d  = 1'b0;

        last   = (cnt_q == CW'(SLOT - 1));
        rf_dec = (state_q == SRFS) && last;

        // Latest CPU request wins; a simultaneous write edge beats a read edge.
        if (rise[0] | rise[1]) begin
            cpu_pend_d = 1'b1;
            cpu_wr_d   = rise[1];
            cpu_a_d    = cpuA;
            cpu_d_d    = cpuD;
        end

        if (rise[2] && !rf_dec)      rf_cnt_d = (rf_cnt_q == 2'd3) ? 2'd3 : rf_cnt_q + 2'd1;
        else if (rf_dec && !rise[2]) rf_cnt_d = rf_cnt_q - 2'd1;
        if (wdt_hit && rf_cnt_d == 2'd0) rf_cnt_d = 2'd1;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (ready) begin
                if (cpu_pend_d) begin
                    state_d    = SCPU;
                    cpu_pend_d = 1'b0;
                    slot_wr_d  = cpu_wr_d;
                    sdr_a_d    = cpu_a_d;
                    sdr_d_d    = dup_byte(cpu_d_d);
                    sdr_wr_d   = cpu_wr_d;
                    sdr_rd_d   = !cpu_wr_d;
                end else if (rf_cnt_d != 2'd0) begin
                    state_d  = SRFS;
                    sdr_rf_d = 1'b1;
                // The ack cycle still sees the old dmaReq; skip it to avoid a duplicate slot.
                end else if (dmaReq && !dma_ack_q) begin
                    state_d   = SDMA;
                    slot_wr_d = dmaWe;
                    sdr_a_d   = dmaA;
                    sdr_d_d   = dup_byte(dmaD);
                    sdr_wr_d  = dmaWe;
                    sdr_rd_d  = !dmaWe;
                end
            end
        end else if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == SCPU && !slot_wr_q) cpu_q_d = sdrQ[7:0];
            if (state_q == SDMA) begin
                dma_ack_d = 1'b1;
                if (!slot_wr_q) dma_q_d = sdrQ[7:0];
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cpu_pend_q <= 1'b0;
            cpu_wr_q   <= 1'b0;
            cpu_a_q    <= '0;
            cpu_d_q    <= '0;
            rf_cnt_q   <= '0;
            slot_wr_q  <= 1'b0;
            sdr_rd_q   <= 1'b0;
            sdr_wr_q   <= 1'b0;
            sdr_rf_q   <= 1'b0;
            sdr_a_q    <= '0;
            sdr_d_q    <= '0;
            cpu_q_q    <= '0;
            dma_q_q    <= '0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_pend_q <= cpu_pend_d;
            cpu_wr_q   <= cpu_wr_d;
            cpu_a_q    <= cpu_a_d;
            cpu_d_q    <= cpu_d_d;
            rf_cnt_q   <= rf_cnt_d;
            slot_wr_q  <= slot_wr_d;
            sdr_rd_q   <= sdr_rd_d;
            sdr_wr_q   <= sdr_wr_d;
            sdr_rf_q   <= sdr_rf_d;
            sdr_a_q    <= sdr_a_d;
            sdr_d_q    <= sdr_d_d;
            cpu_q_q    <= cpu_q_d;
            dma_q_q    <= dma_q_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

    assign cpuQ   = cpu_q_q;
    assign dmaQ   = dma_q_q;
    assign dmaAck = dma_ack_q;
    assign sdrRd  = sdr_rd_q;
    assign sdrWr  = sdr_wr_q;
    assign sdrRf  = sdr_rf_q;
    assign sdrA   = sdr_a_q;
    assign sdrD   = sdr_d_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, CPU read/write, DMA, priority, ready gating,
// mid-slot reset and refresh watchdog (SDRAM_ARB_WDT_EN).
module tb_sdram_arbiter;

    localparam int AW   = 24;
    localparam int SLOT = 8;
    localparam int WDT  = 64;

    logic          clock = 1'b0;
    logic          reset, ready;
    logic          cpuRd, cpuWr, cpuRf;
    logic [AW-1:0] cpuA;
    logic [7:0]    cpuD, cpuQ;
    logic          dmaReq, dmaWe, dmaAck;
    logic [AW-1:0] dmaA;
    logic [7:0]    dmaD, dmaQ;
    logic          sdrRd, sdrWr, sdrRf, busy;
    logic [AW-1:0] sdrA;
    logic [15:0]   sdrD, sdrQ;

    int checks = 0;
    int failures = 0;

    sdram_arbiter #(.AW(AW), .SLOT(SLOT), .WDT(WDT)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuRf(cpuRf), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ),
        .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaA(dmaA), .dmaD(dmaD), .dmaQ(dmaQ), .dmaAck(dmaAck),
        .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrRf(sdrRf), .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n, bad, t0;
        int kinds[3];
        int when[3];

        reset = 1'b1; ready = 1'b1;
        cpuRd = 1'b0; cpuWr = 1'b0; cpuRf = 1'b0; cpuA = '0; cpuD = '0;
        dmaReq = 1'b0; dmaWe = 1'b0; dmaA = '0; dmaD = '0; sdrQ = '0;

        // 1: reset with cpuRd toggling, then quiet idle
        for (int i = 0; i < 4; i++) begin
            cpuRd = ~cpuRd;
            tick();
            chk("rst_ctrl", {59'd0, sdrRd, sdrWr, sdrRf, dmaAck, busy}, 64'd0);
            chk("rst_data", {cpuQ, dmaQ, sdrA, sdrD}, 64'd0);
        end
        cpuRd = 1'b0;
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sdrRd | sdrWr | sdrRf | busy) n++;
        end
        chk("idle_quiet", n, 0);

        // 2: CPU read
        cpuA = 24'h004000; sdrQ = 16'h5A5A; cpuRd = 1'b1;
        tick();
        chk("rd_strobe", {sdrRd, sdrWr, sdrRf, busy}, 4'b1001);
        chk("rd_addr", sdrA, 24'h004000);
        tick();
        chk("rd_pulse", {sdrRd, busy}, 2'b01);
        cpuRd = 1'b0;
        repeat (SLOT - 1) tick();
        chk("rd_data", cpuQ, 8'h5A);
        chk("rd_done", busy, 1'b0);

        // 3: CPU write, data held the whole slot, cpuQ untouched
        cpuA = 24'h000321; cpuD = 8'hC3; sdrQ = 16'h1111; cpuWr = 1'b1;
        tick();
        chk("wr_strobe", {sdrRd, sdrWr, sdrRf}, 3'b010);
        chk("wr_data", sdrD, 16'hC3C3);
        bad = 0;
        for (int i = 0; i < SLOT - 1; i++) begin
            tick();
            if (sdrWr | sdrRd | sdrRf | dmaAck | !busy || sdrD !== 16'hC3C3 || sdrA !== 24'h000321) bad++;
        end
        chk("wr_hold", bad, 0);
        tick();
        chk("wr_done", busy, 1'b0);
        chk("wr_cpuq", cpuQ, 8'h5A);
        cpuWr = 1'b0;
        tick();

        // 4: DMA read, CPU write edge mid-slot wins over re-asserted dmaReq
        dmaA = 24'h010000; dmaWe = 1'b0; dmaReq = 1'b1; sdrQ = 16'h00A7;
        tick();
        chk("dma_strobe", {sdrRd, sdrWr, sdrRf}, 3'b100);
        chk("dma_addr", sdrA, 24'h010000);
        tick();
        tick();
        cpuA = 24'h000123; cpuD = 8'h3C; cpuWr = 1'b1;
        tick();
        repeat (SLOT - 4) tick();
        chk("dma_noack", {dmaAck, busy}, 2'b01);
        tick();
        chk("dma_ack", {dmaAck, busy, sdrRd, sdrWr, sdrRf}, 5'b10000);
        chk("dma_q", dmaQ, 8'hA7);
        tick();
        chk("cpu_first", {sdrWr, sdrRd, dmaAck}, 3'b100);
        chk("cpu_after_dma", {sdrA, sdrD}, {24'h000123, 16'h3C3C});
        dmaReq = 1'b0; cpuWr = 1'b0;
        repeat (SLOT) tick();
        chk("dma_cpu_done", busy, 1'b0);

        // 5: simultaneous refresh, read and DMA edges -> CPU, RFSH, DMA
        sdrQ = 16'h0042; dmaA = 24'h020000; dmaWe = 1'b0; cpuA = 24'h000777;
        cpuRf = 1'b1; cpuRd = 1'b1; dmaReq = 1'b1;
        n = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 2) begin cpuRd = 1'b0; cpuRf = 1'b0; end
            if (sdrRd | sdrWr | sdrRf) begin
                if (n < 3) begin
                    kinds[n] = sdrRf ? 2 : ((sdrA === 24'h000777) ? 1 : 3);
                    when[n]  = t;
                end
                n++;
            end
            if (dmaAck) dmaReq = 1'b0;
        end
        chk("prio_count", n, 3);
        chk("prio_order", {kinds[0][7:0], kinds[1][7:0], kinds[2][7:0]}, 24'h010203);
        chk("prio_times", {when[0][7:0], when[1][7:0], when[2][7:0]}, {8'd1, 8'd10, 8'd19});
        chk("prio_data", {cpuQ, dmaQ}, 16'h4242);

        // ready low: request retained, granted once ready rises
        ready = 1'b0; cpuA = 24'h000055; cpuRd = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (sdrRd | sdrWr | sdrRf | busy) n++;
        end
        chk("notready_hold", n, 0);
        ready = 1'b1;
        tick();
        chk("ready_grant", {sdrRd, sdrA}, {1'b1, 24'h000055});
        cpuRd = 1'b0;
        repeat (SLOT) tick();

        // reset mid DMA slot: no ack afterwards
        dmaA = 24'h030000; dmaWe = 1'b1; dmaD = 8'h99; dmaReq = 1'b1;
        tick();
        chk("rst_slot_grant", {sdrWr, sdrD}, {1'b1, 16'h9999});
        dmaReq = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_slot_abort", {busy, dmaAck, sdrRd, sdrWr, sdrRf}, 5'b0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < SLOT + 2; i++) begin
            tick();
            if (dmaAck | sdrRd | sdrWr | sdrRf | busy) n++;
        end
        chk("rst_slot_quiet", n, 0);

        // 6: refresh watchdog
`ifdef SDRAM_ARB_WDT_EN
        t0 = -1;
        for (int i = 0; i < 300 && t0 < 0; i++) begin
            tick();
            if (sdrRf) t0 = i;
        end
        chk("wdt_first", (t0 >= 0), 1'b1);
        n = -1;
        for (int i = 1; i <= 300 && n < 0; i++) begin
            tick();
            if (sdrRf) n = i;
        end
        chk("wdt_period", n, WDT + SLOT + 1);
`else
        t0 = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sdrRf) n++;
        end
        chk("nowdt_refresh", n + t0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
